// File: rtl/fetch_pc_unit_pkg.sv
// Fetch-stage constants shared with decode/execute, plus the redirect target helper.
package fetch_pc_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_2000;
  localparam logic [31:0] TRAP_PC_DEF  = 32'h0000_0100;
  localparam logic [31:0] PC_INC       = 32'd4;

  // Jump has priority over a simultaneous branch; JAL/JALR targets drop bit 0.
  function automatic logic [31:0] redirect_target(
    input logic        jump_valid,
    input logic [31:0] jump_target,
    input logic [31:0] branch_target
  );
    return jump_valid ? (jump_target & ~32'h1) : branch_target;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_event_counter.sv
// Wrapping event counter; clear has priority over increment.
module fetch_pc_unit_event_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + WIDTH'(1);
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator: applies X-stage redirects, parks them across stalls,
// kills wrong-path F/D instructions and counts branch events.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter logic [31:0] TRAP_PC     = TRAP_PC_DEF,
  parameter int unsigned KILL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        branch_valid_x,
  input  logic        branch_taken_x,
  input  logic [31:0] branch_target_x,
  input  logic        jump_valid_x,
  input  logic [31:0] jump_target_x,
  input  logic        cnt_clr,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_d,
  output logic        flush_fd,
  output logic        misalign,
  output logic [31:0] br_count,
  output logic [31:0] br_taken_count
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  localparam int KW = 2;
  localparam logic [KW-1:0] KILL_INIT = KW'(KILL_CYCLES);

  state_t        state, state_nx;
  logic [31:0]   pc, pc_nx, pc_d_nx, pend_tgt, pend_tgt_nx;
  logic [31:0]   tgt, eff_tgt;
  logic          pend_mis, pend_mis_nx, mis_nx;
  logic [KW-1:0] kill_cnt, kill_nx;
  logic          adv, redir, tgt_mis;

  always_comb begin
    adv     = !stall & imem_ready;
    redir   = jump_valid_x | (branch_valid_x & branch_taken_x);
    tgt     = redirect_target(jump_valid_x, jump_target_x, branch_target_x);
    tgt_mis = tgt[1];
    eff_tgt = tgt_mis ? TRAP_PC : tgt;
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    pc_d_nx     = pc_d;
    pend_tgt_nx = pend_tgt;
    pend_mis_nx = pend_mis;
    kill_nx     = kill_cnt;
    mis_nx      = 1'b0;
    case (state)
      RUN: begin
        if (redir && adv) begin
          pc_nx   = eff_tgt;
          kill_nx = KILL_INIT;
          mis_nx  = tgt_mis;
        end else if (redir) begin
          pend_tgt_nx = eff_tgt;
          pend_mis_nx = tgt_mis;
          state_nx    = PEND;
        end else if (adv) begin
          pc_nx = pc + PC_INC;
          // Killed slots never expose their PC to decode.
          if (!flush_fd) pc_d_nx = pc;
          if (kill_cnt != '0) kill_nx = kill_cnt - KW'(1);
        end
      end
      PEND: begin
        // A redirect arriving in the release cycle is newer than the parked one.
        if (adv) begin
          pc_nx    = redir ? eff_tgt : pend_tgt;
          mis_nx   = redir ? tgt_mis : pend_mis;
          kill_nx  = KILL_INIT;
          state_nx = RUN;
        end else if (redir) begin
          pend_tgt_nx = eff_tgt;
          pend_mis_nx = tgt_mis;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      pc_d     <= RESET_PC;
      pend_tgt <= RESET_PC;
      pend_mis <= 1'b0;
      kill_cnt <= '0;
      misalign <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      pc_d     <= pc_d_nx;
      pend_tgt <= pend_tgt_nx;
      pend_mis <= pend_mis_nx;
      kill_cnt <= kill_nx;
      misalign <= mis_nx;
    end
  end

  assign imem_addr = pc;
  assign flush_fd  = (kill_cnt != '0);

  fetch_pc_unit_event_counter #(.WIDTH(32)) u_br_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (branch_valid_x & adv),
    .cnt (br_count)
  );

  fetch_pc_unit_event_counter #(.WIDTH(32)) u_br_taken_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (branch_valid_x & branch_taken_x & adv),
    .cnt (br_taken_count)
  );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed scenarios then random traffic.
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC  = 32'h0000_2000;
  localparam logic [31:0] TRAP    = 32'h0000_0100;
  localparam int          KILL    = 1;

  logic        clk = 1'b0;
  logic        rst, stall, imem_ready, branch_valid_x, branch_taken_x;
  logic        jump_valid_x, cnt_clr;
  logic [31:0] branch_target_x, jump_target_x;
  logic [31:0] imem_addr, pc_d, br_count, br_taken_count;
  logic        flush_fd, misalign;

  logic        wc_clr, wc_inc;
  logic [3:0]  wc_cnt;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] pc, pcd, brc, tkc;
    logic        flush, mis;
  } exp_t;
  exp_t sb[$];

  // Reference state, kept as plain numbers.
  logic [31:0] m_pc, m_pcd, m_ptgt, m_brc, m_tkc;
  bit          m_pend, m_pmis, m_mis;
  int          m_kill;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
    .branch_valid_x(branch_valid_x), .branch_taken_x(branch_taken_x),
    .branch_target_x(branch_target_x), .jump_valid_x(jump_valid_x),
    .jump_target_x(jump_target_x), .cnt_clr(cnt_clr),
    .imem_addr(imem_addr), .pc_d(pc_d), .flush_fd(flush_fd),
    .misalign(misalign), .br_count(br_count), .br_taken_count(br_taken_count)
  );

  fetch_pc_unit_event_counter #(.WIDTH(4)) u_wc (
    .clk(clk), .rst(rst), .clr(wc_clr), .inc(wc_inc), .cnt(wc_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, st, rdy, bv, bt, input logic [31:0] btg,
                       input bit jv, input logic [31:0] jtg, input bit clr);
    bit adv, redir;
    logic [31:0] t, e;
    bit mis;
    if (r) begin
      m_pc = RST_PC; m_pcd = RST_PC; m_pend = 0; m_kill = 0; m_mis = 0;
      m_brc = 0; m_tkc = 0;
      return;
    end
    adv   = !st && rdy;
    redir = jv || (bv && bt);
    t     = jv ? jtg - (jtg % 2) : btg;
    mis   = (t % 4) >= 2;
    e     = mis ? TRAP : t;
    m_mis = 0;
    if (clr) begin
      m_brc = 0; m_tkc = 0;
    end else if (adv && bv) begin
      m_brc = m_brc + 1;
      if (bt) m_tkc = m_tkc + 1;
    end
    if (adv && (redir || m_pend)) begin
      m_pc   = redir ? e : m_ptgt;
      m_mis  = redir ? mis : m_pmis;
      m_kill = KILL;
      m_pend = 0;
    end else if (adv) begin
      if (m_kill == 0) m_pcd = m_pc;
      m_pc = m_pc + 4;
      if (m_kill > 0) m_kill--;
    end else if (redir) begin
      m_pend = 1; m_ptgt = e; m_pmis = mis;
    end
  endtask

  task automatic cyc(input bit r, st, rdy, bv, bt, input logic [31:0] btg,
                     input bit jv, input logic [31:0] jtg, input bit clr);
    exp_t e;
    bit was_rst;
    @(negedge clk);
    was_rst = rst;
    rst = r; stall = st; imem_ready = rdy; branch_valid_x = bv; branch_taken_x = bt;
    branch_target_x = btg; jump_valid_x = jv; jump_target_x = jtg; cnt_clr = clr;
    model(r, st, rdy, bv, bt, btg, jv, jtg, clr);
    e.pc = m_pc; e.pcd = m_pcd; e.flush = (m_kill != 0); e.mis = m_mis;
    e.brc = m_brc; e.tkc = m_tkc;
    sb.push_back(e);
    if (r && !was_rst) begin
      #1;
      chk("async_rst_imem_addr", imem_addr, RST_PC);
      chk("async_rst_flush", {31'b0, flush_fd}, 32'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  // Monitor: every cycle the DUT presents a full output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("imem_addr", imem_addr, e.pc);
        chk("pc_d", pc_d, e.pcd);
        chk("flush_fd", {31'b0, flush_fd}, {31'b0, e.flush});
        chk("misalign", {31'b0, misalign}, {31'b0, e.mis});
        chk("br_count", br_count, e.brc);
        chk("br_taken_count", br_taken_count, e.tkc);
      end
    end
  end

  initial begin
    logic [31:0] rt;
    rst = 1; stall = 0; imem_ready = 1; branch_valid_x = 0; branch_taken_x = 0;
    branch_target_x = 0; jump_valid_x = 0; jump_target_x = 0; cnt_clr = 0;
    wc_clr = 0; wc_inc = 0;

    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(3);
    // Taken then not-taken branch.
    cyc(0, 0, 1, 1, 1, 32'h2100, 0, 0, 0);
    idle(2);
    cyc(0, 0, 1, 1, 0, 32'h2200, 0, 0, 0);
    idle(2);
    // Taken branch parked across a 3-cycle stall.
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 1, 32'h3000, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 32'h3000, 0, 0, 0);
    idle(2);
    // imem_ready low acts as a stall.
    cyc(0, 0, 0, 1, 1, 32'h3400, 0, 0, 0);
    idle(2);
    // Jump beats branch, bit 0 dropped.
    cyc(0, 0, 1, 1, 1, 32'h5000, 1, 32'h2401, 0);
    idle(2);
    // Misaligned jump goes to trap.
    cyc(0, 0, 1, 0, 0, 0, 1, 32'h2402, 0);
    idle(2);
    // Parked target overwritten by a newer redirect; misalign shows at apply.
    cyc(0, 1, 1, 0, 0, 0, 1, 32'h4000, 0);
    cyc(0, 1, 1, 0, 0, 0, 1, 32'h4402, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Back-to-back redirects reload the kill window.
    cyc(0, 0, 1, 0, 0, 0, 1, 32'h6000, 0);
    cyc(0, 0, 1, 0, 0, 0, 1, 32'h6100, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Clear beats a simultaneous taken branch.
    cyc(0, 0, 1, 1, 1, 32'h2800, 0, 0, 1);
    idle(1);
    // Reset while parked: no redirect afterwards.
    cyc(0, 1, 1, 1, 1, 32'h7000, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      rt = $urandom;
      if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
          rt, $urandom_range(0, 6) == 0, rt ^ {31'b0, 1'($urandom_range(0, 1))},
          $urandom_range(0, 29) == 0);
    end
    idle(1);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", sb.size(), 0);

    // Narrow counter instance: wrap and clear priority.
    @(negedge clk); wc_clr = 1; wc_inc = 0;
    @(negedge clk); wc_clr = 0; wc_inc = 1;
    repeat (15) @(negedge clk);
    chk("wc_full", {28'b0, wc_cnt}, 32'd15);
    @(negedge clk);
    chk("wc_wrap", {28'b0, wc_cnt}, 32'd0);
    @(negedge clk);
    chk("wc_inc", {28'b0, wc_cnt}, 32'd1);
    wc_clr = 1;
    @(negedge clk);
    chk("wc_clr_priority", {28'b0, wc_cnt}, 32'd0);
    wc_clr = 0; wc_inc = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-stage PC generator that directly consumes the execute-stage branch comparison result (branch_taken) and jump targets.
- Holds the architectural fetch PC and drives the instruction-memory address.
- On a redirect, kills wrong-path instructions in F/D and parks redirects that arrive during stalls.
- Also keeps branch and taken-branch event counters for performance reads.

Parameters:
- RESET_PC, 32'h0000_2000, PC loaded on reset.
- TRAP_PC, 32'h0000_0100, redirect destination for a misaligned target.
- KILL_CYCLES, 1, advancing cycles for which flush_fd stays high after a redirect is applied (1..3).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  global pipeline stall; PC and pipeline registers hold.
- imem_ready  in  1  instruction memory can accept an address this cycle.
- branch_valid_x  in  1  X-stage instruction is a conditional branch.
- branch_taken_x  in  1  comparator result for that branch.
- branch_target_x  in  32  PC+imm target of the branch.
- jump_valid_x  in  1  X-stage instruction is JAL/JALR.
- jump_target_x  in  32  raw jump target; bit 0 is cleared internally.
- cnt_clr  in  1  synchronous clear of both counters.
- imem_addr  out  32  fetch address; equals the PC register.
- pc_d  out  32  PC of the instruction entering decode.
- flush_fd  out  1  kill the F/D instructions; registered.
- misalign  out  1  one-cycle pulse when a target is misaligned.
- br_count  out  32  accepted conditional branches.
- br_taken_count  out  32  accepted taken branches.

Behaviour:
- adv = !stall & imem_ready. R = jump_valid_x | (branch_valid_x & branch_taken_x).
- Target: T = jump_valid_x ? {jump_target_x[31:1],1'b0} : branch_target_x. Jump wins if both valid, which is illegal but defined.
- Misalignment: if T[1] = 1, the effective target is TRAP_PC and misalign is registered high for exactly one cycle when the redirect is applied.
- Reset values: pc = RESET_PC, pc_d = RESET_PC, state RUN, kill_cnt = 0, flush_fd = 0, misalign = 0, both counters = 0. Reset may assert at any cycle and aborts any pending redirect.
- State RUN:
  - R & adv: pc <= effective target, kill_cnt <= KILL_CYCLES, stay in RUN.
  - R & !adv: pend_tgt <= effective target, go to PEND; pc holds.
  - !R & adv: pc <= pc+4 (32-bit wrap); pc_d <= pc.
  - Otherwise all registers hold.
- State PEND:
  - R still asserted: pend_tgt is overwritten; newest target wins.
  - adv: pc <= pend_tgt, kill_cnt <= KILL_CYCLES, return to RUN.
  - misalign pulses at application time, not at capture time.
- Kill counter:
  - flush_fd = (kill_cnt != 0), registered.
  - kill_cnt decrements only on adv cycles and never goes below 0.
  - pc_d is not updated while flush_fd = 1, so killed instructions never expose a PC.
  - A new redirect during a kill window reloads kill_cnt to KILL_CYCLES.
- Latency: a redirect accepted in cycle n gives imem_addr = target in cycle n+1 and flush_fd = 1 in cycle n+1.
- Counters:
  - br_count increments on branch_valid_x & adv.
  - br_taken_count increments on branch_valid_x & branch_taken_x & adv.
  - Counting only on adv cycles avoids double counts while stalled.
  - Both wrap modulo 2^32.
  - cnt_clr wins over a simultaneous increment.
- imem_ready low with stall low behaves exactly like a stall for this block.

Decomposition:
- Shared constants (RESET_PC, TRAP_PC defaults, PC increment 4) go in the project's common constants include, shared with the decode/execute stages.
- State encoding (RUN=1'b0, PEND=1'b1) is local.
- One natural sub-module, event_counter: 32-bit counter with clr and inc, clr-priority. It is instantiated twice.

Test Plan:
- Reset release, stall=0, imem_ready=1, no redirects: imem_addr = 0x2000, 0x2004, 0x2008 on successive cycles; flush_fd = 0; pc_d lags imem_addr by one cycle.
- Taken branch with target 0x2100 while PC = 0x200C: next cycle imem_addr = 0x2100 and flush_fd = 1 for 1 cycle (KILL_CYCLES=1); br_count = 1, br_taken_count = 1. Not-taken branch: PC continues +4, br_count = 2, br_taken_count = 1.
- Branch taken to 0x3000 with stall=1 held for 3 cycles: imem_addr holds and br_count does not change. On stall release, imem_addr = 0x3000 the next cycle, flush_fd = 1, and counters increment exactly once.
- JALR with jump_target_x = 0x2401 alongside a taken branch to 0x5000: redirect goes to 0x2400 (jump wins, bit 0 cleared); misalign = 0.
- Jump target 0x2402: imem_addr = 0x0100 (TRAP_PC) next cycle and misalign is high for exactly 1 cycle.
- Counter and reset edge cases:
  - Counters at 0xFFFF_FFFF plus an accepted taken branch: both wrap to 0.
  - cnt_clr with a simultaneous branch: both counters read 0.
  - rst asserted while in PEND: imem_addr = 0x2000 immediately, with no later redirect.
